// File: rtl/pe_chain_sequencer.sv
// Job sequencer for a chain of N PEs: streams A/B operand beats into the head PE,
// waits for the chain to finish, then drains every PE result memory onto a valid/ready stream.
module pe_chain_sequencer #(
   parameter int log_size = 2,
   parameter int timeout  = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [2*log_size-1:0]         src_addr,
   input  logic [31:0]                   src_a_data,
   input  logic [31:0]                   src_b_data,
   output logic [31:0]                   pe_a,
   output logic [31:0]                   pe_b,
   output logic                          pe_stb,
   output logic                          pe_b_valid,
   input  logic                          pe_input_ack,
   input  logic                          pe_output_stb,
   output logic [log_size-1:0]           pe_rd_addr,
   output logic [(1<<log_size)-1:0]      pe_mem_select,
   input  logic [32*(1<<log_size)-1:0]   pe_c_bus,
   output logic [31:0]                   res_data,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic                          res_last
);

   localparam int N         = 1 << log_size;
   localparam int DATA_W    = 32;
   localparam int NN        = N * N;
   localparam int LAST_BEAT = NN + N - 2;
   localparam int JW        = 2 * log_size + 1;
   localparam int WDW       = $clog2(timeout + 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_FETCH = 4'd1;
   localparam logic [3:0] S_LOAD  = 4'd2;
   localparam logic [3:0] S_OFFER = 4'd3;
   localparam logic [3:0] S_GAP   = 4'd4;
   localparam logic [3:0] S_WAIT  = 4'd5;
   localparam logic [3:0] S_READ  = 4'd6;
   localparam logic [3:0] S_CAPT  = 4'd7;
   localparam logic [3:0] S_OUT   = 4'd8;
   localparam logic [3:0] S_FIN   = 4'd9;

   logic [3:0]            state;
   logic [3:0]            state_nxt;
   logic [JW-1:0]         j;
   logic [2*log_size-1:0] pw;
   logic [WDW-1:0]        wd;
   logic                  ack_q;
   logic                  ack_rise;
   logic                  flush;
   logic                  last_beat;
   logic                  last_word;
   logic                  wd_hit;
   logic                  wd_fire;

   assign ack_rise  = pe_input_ack & ~ack_q;
   assign flush     = (j >= JW'(NN));
   assign last_beat = (j == JW'(LAST_BEAT));
   assign last_word = (pw == '1);
   assign wd_hit    = (wd == WDW'(timeout - 1));

   // pw packs {PE index, word index}, so a plain increment walks results PE-major.
   assign src_addr   = j[2*log_size-1:0];
   assign pe_rd_addr = pw[log_size-1:0];
   assign pe_stb     = (state == S_OFFER);
   assign busy       = (state != S_IDLE) && (state != S_FIN);
   assign done       = (state == S_FIN);
   assign res_valid  = (state == S_OUT);
   assign res_last   = (state == S_OUT) && last_word;

   always_comb begin
      pe_mem_select = '0;
      if (state == S_READ)
         pe_mem_select = {{(N-1){1'b0}}, 1'b1} << pw[2*log_size-1:log_size];
   end

   always_comb begin
      state_nxt = state;
      wd_fire   = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = flush ? S_OFFER : S_LOAD;
         S_LOAD:  state_nxt = S_OFFER;
         S_OFFER: begin
            if (ack_rise) begin
               state_nxt = S_GAP;
            end else if (wd_hit) begin
               state_nxt = S_IDLE;
               wd_fire   = 1'b1;
            end
         end
         S_GAP:   state_nxt = last_beat ? S_WAIT : S_FETCH;
         S_WAIT: begin
            if (pe_output_stb) begin
               state_nxt = S_READ;
            end else if (wd_hit) begin
               state_nxt = S_IDLE;
               wd_fire   = 1'b1;
            end
         end
         S_READ:  state_nxt = S_CAPT;
         S_CAPT:  state_nxt = S_OUT;
         S_OUT:   if (res_ready) state_nxt = last_word ? S_FIN : S_READ;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         j          <= '0;
         pw         <= '0;
         wd         <= '0;
         ack_q      <= 1'b0;
         error      <= 1'b0;
         pe_a       <= '0;
         pe_b       <= '0;
         pe_b_valid <= 1'b0;
         res_data   <= '0;
      end else begin
         state <= state_nxt;
         ack_q <= pe_input_ack;
         // Watchdog measures time spent in the current state; saturates where it cannot fire.
         if (state_nxt != state)
            wd <= '0;
         else if (wd != '1)
            wd <= wd + 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  j     <= '0;
               end
            end
            S_FETCH: begin
               if (flush) begin
                  pe_a       <= '0;
                  pe_b       <= '0;
                  pe_b_valid <= 1'b0;
               end
            end
            S_LOAD: begin
               pe_a       <= src_a_data;
               pe_b       <= src_b_data;
               pe_b_valid <= 1'b1;
            end
            S_GAP:  j <= j + 1'b1;
            S_WAIT: if (pe_output_stb) pw <= '0;
            S_CAPT: res_data <= pe_c_bus[{pw[2*log_size-1:log_size], 5'd0} +: DATA_W];
            S_OUT:  if (res_ready) pw <= pw + 1'b1;
            default: ;
         endcase
         if (wd_fire)
            error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pe_chain_sequencer.sv
// Bench for pe_chain_sequencer: source memory, PE chain and result consumer models,
// with a queue-based expectation of operand beats and result words.
`timescale 1ns/1ps
module tb_pe_chain_sequencer;

   localparam int LS = 1;
   localparam int N  = 1 << LS;
   localparam int NN = N * N;
   localparam int NB = NN + N - 1;
   localparam int TO = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, error;
   logic [2*LS-1:0]   src_addr;
   logic [31:0]       src_a_data, src_b_data;
   logic [31:0]       pe_a, pe_b;
   logic              pe_stb, pe_b_valid;
   logic              pe_input_ack, pe_output_stb;
   logic [LS-1:0]     pe_rd_addr;
   logic [N-1:0]      pe_mem_select;
   logic [32*N-1:0]   pe_c_bus;
   logic [31:0]       res_data;
   logic              res_valid, res_ready, res_last;

   always #5 clk = ~clk;

   pe_chain_sequencer #(.log_size(LS), .timeout(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .src_addr(src_addr), .src_a_data(src_a_data), .src_b_data(src_b_data),
      .pe_a(pe_a), .pe_b(pe_b), .pe_stb(pe_stb), .pe_b_valid(pe_b_valid),
      .pe_input_ack(pe_input_ack), .pe_output_stb(pe_output_stb),
      .pe_rd_addr(pe_rd_addr), .pe_mem_select(pe_mem_select), .pe_c_bus(pe_c_bus),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct { logic [31:0] a; logic [31:0] b; logic bv; } beat_t;

   logic [31:0] a_mem [NN];
   logic [31:0] b_mem [NN];
   logic [31:0] pe_mem [N][N];

   beat_t       beat_q[$];
   logic [31:0] res_q[$];
   logic [31:0] acc_a[$];
   logic        acc_bv[$];
   logic [31:0] res_log[$];
   logic        last_log[$];
   int          beats, xfers, dones, stall;

   int ack_mode = 0, ack_dly = 2, out_dly = 2, cons_mode = 0;

   // Source memory: one-cycle read latency
   always @(posedge clk) begin
      src_a_data <= a_mem[src_addr];
      src_b_data <= b_mem[src_addr];
   end

   // PE result memories: selected slice valid one cycle after select, others noise
   always @(posedge clk) begin
      for (int p = 0; p < N; p++)
         pe_c_bus[32*p +: 32] <= pe_mem_select[p] ? pe_mem[p][pe_rd_addr] : $urandom;
   end

   // PE chain handshake model (reset together with the sequencer)
   int   acnt, hcnt, nacc, dcnt;
   logic ackd, hold, stuck_done;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_input_ack <= 1'b0; pe_output_stb <= 1'b0; ackd <= 1'b0; hold <= 1'b0;
         stuck_done <= 1'b0; acnt <= 0; hcnt <= 0; nacc <= 0; dcnt <= 0;
      end else begin
         ackd          <= pe_input_ack;
         pe_output_stb <= 1'b0;
         if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) pe_output_stb <= 1'b1;
         end
         if (pe_stb && pe_input_ack && !ackd) begin
            nacc <= nacc + 1;
            if ((nacc + 1) % NB == 0) dcnt <= out_dly;
         end
         if (ack_mode == 1) begin
            pe_input_ack <= 1'b0;
         end else if (hold) begin
            if (pe_stb) begin
               hcnt <= hcnt + 1;
               if (hcnt == 5) pe_input_ack <= 1'b0;
               if (hcnt == 6) begin
                  pe_input_ack <= 1'b1; hold <= 1'b0; stuck_done <= 1'b1;
               end
            end
         end else begin
            hcnt <= 0;
            if (!pe_stb) begin
               pe_input_ack <= 1'b0; acnt <= 0;
            end else if (!pe_input_ack) begin
               if (acnt + 1 >= ack_dly) begin pe_input_ack <= 1'b1; acnt <= 0; end
               else acnt <= acnt + 1;
            end
            if (ack_mode == 2 && !stuck_done && pe_stb && pe_input_ack && !ackd) hold <= 1'b1;
         end
         if (ack_mode != 2) stuck_done <= 1'b0;
      end
   end

   // Result consumer
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (cons_mode)
            0: res_ready = 1'b1;
            1: res_ready = ($urandom_range(0, 2) != 0);
            2: begin
               if (xfers == 1 && stall < 7 && (res_valid || stall > 0)) begin
                  if (stall > 0) begin
                     chk("stall_valid", res_valid, 1);
                     chk("stall_data", res_data, pe_mem[0][1]);
                  end
                  res_ready = 1'b0;
                  stall++;
               end else res_ready = 1'b1;
            end
            default: res_ready = 1'b0;
         endcase
      end
   end

   // Compare process: every cycle, outputs against the expected beat/result queues
   logic ack_prev = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            ack_prev = 1'b0;
         end else begin
            if (pe_stb) begin
               if (beat_q.size() == 0) chk("extra_beat", pe_stb, 0);
               else begin
                  chk("pe_a", pe_a, beat_q[0].a);
                  chk("pe_b", pe_b, beat_q[0].b);
                  chk("pe_b_valid", pe_b_valid, beat_q[0].bv);
                  if (pe_input_ack && !ack_prev) begin
                     acc_a.push_back(pe_a);
                     acc_bv.push_back(pe_b_valid);
                     void'(beat_q.pop_front());
                     beats++;
                  end
               end
            end
            if (res_valid) begin
               if (res_q.size() == 0) chk("extra_result", res_valid, 0);
               else begin
                  chk("res_data", res_data, res_q[0]);
                  chk("res_last", res_last, res_q.size() == 1);
                  if (res_ready) begin
                     res_log.push_back(res_data);
                     last_log.push_back(res_last);
                     void'(res_q.pop_front());
                     xfers++;
                  end
               end
            end else chk("res_last_idle", res_last, 0);
            chk("sel_onehot", $countones(pe_mem_select) <= 1, 1);
            if (done) begin
               chk("done_beats_left", beat_q.size(), 0);
               chk("done_results_left", res_q.size(), 0);
               chk("done_busy", busy, 0);
               dones++;
            end
            ack_prev = pe_input_ack;
         end
      end
   end

   task automatic arm();
      beat_q.delete(); res_q.delete(); acc_a.delete(); acc_bv.delete();
      res_log.delete(); last_log.delete();
      beats = 0; xfers = 0; stall = 0;
      for (int j = 0; j < NB; j++) begin
         beat_t bt;
         if (j < NN) begin bt.a = a_mem[j]; bt.b = b_mem[j]; bt.bv = 1'b1; end
         else begin bt.a = '0; bt.b = '0; bt.bv = 1'b0; end
         beat_q.push_back(bt);
      end
      for (int p = 0; p < N; p++)
         for (int w = 0; w < N; w++) res_q.push_back(pe_mem[p][w]);
   endtask

   task automatic randomize_data();
      for (int j = 0; j < NN; j++) begin
         a_mem[j] = ($urandom & 32'hFFFF_FFF0) | 32'(j + 1);
         b_mem[j] = $urandom;
      end
      for (int p = 0; p < N; p++)
         for (int w = 0; w < N; w++) pe_mem[p][w] = $urandom;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_stb(input string nm);
      int k = 0;
      while (!pe_stb && k < 100) begin @(negedge clk); k++; end
      if (!pe_stb) chk(nm, pe_stb, 1);
   endtask

   task automatic run_job(input string nm);
      int d0 = dones;
      int k  = 0;
      arm();
      pulse_start();
      @(negedge clk);
      chk({nm, "_busy_after_start"}, busy, 1);
      chk({nm, "_error_cleared"}, error, 0);
      while (dones == d0 && k < 3000) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      chk({nm, "_done_count"}, dones - d0, 1);
      chk({nm, "_beats"}, beats, NB);
      chk({nm, "_results"}, xfers, NN);
      chk({nm, "_error"}, error, 0);
      chk({nm, "_busy_end"}, busy, 0);
   endtask

   initial begin
      int d0, k;
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
   end

   initial begin
      int d0;
      int k;
      dones = 0;
      for (int j = 0; j < NN; j++) begin a_mem[j] = '0; b_mem[j] = '0; end
      for (int p = 0; p < N; p++) for (int w = 0; w < N; w++) pe_mem[p][w] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_error", error, 0);
      chk("rst_stb", pe_stb, 0);  chk("rst_bvalid", pe_b_valid, 0);
      chk("rst_pe_a", pe_a, 0);   chk("rst_pe_b", pe_b, 0);
      chk("rst_sel", pe_mem_select, 0); chk("rst_rdaddr", pe_rd_addr, 0);
      chk("rst_src", src_addr, 0); chk("rst_rvalid", res_valid, 0);
      chk("rst_rlast", res_last, 0); chk("rst_rdata", res_data, 0);
      @(posedge clk); #2 rst = 1'b1;
      repeat (2) @(negedge clk);

      // A=[[1,2],[3,4]], B=I in IEEE-754 single; chain returns C=A
      a_mem[0] = 32'h3F80_0000; a_mem[1] = 32'h4000_0000;
      a_mem[2] = 32'h4040_0000; a_mem[3] = 32'h4080_0000;
      b_mem[0] = 32'h3F80_0000; b_mem[1] = 32'h0;
      b_mem[2] = 32'h0;         b_mem[3] = 32'h3F80_0000;
      pe_mem[0][0] = 32'h3F80_0000; pe_mem[0][1] = 32'h4000_0000;
      pe_mem[1][0] = 32'h4040_0000; pe_mem[1][1] = 32'h4080_0000;
      ack_mode = 0; ack_dly = 2; out_dly = 3; cons_mode = 0;
      run_job("directed");
      if (acc_bv.size() == NB) begin
         chk("dir_bv0", acc_bv[0], 1); chk("dir_bv1", acc_bv[1], 1);
         chk("dir_bv2", acc_bv[2], 1); chk("dir_bv3", acc_bv[3], 1);
         chk("dir_bv4", acc_bv[4], 0);
         chk("dir_a1", acc_a[1], 32'h4000_0000); chk("dir_a4", acc_a[4], 32'h0);
      end else chk("dir_beat_log", acc_bv.size(), NB);
      if (res_log.size() == NN) begin
         chk("dir_r0", res_log[0], 32'h3F80_0000); chk("dir_r1", res_log[1], 32'h4000_0000);
         chk("dir_r2", res_log[2], 32'h4040_0000); chk("dir_r3", res_log[3], 32'h4080_0000);
         chk("dir_last2", last_log[2], 0);         chk("dir_last3", last_log[3], 1);
      end else chk("dir_res_log", res_log.size(), NN);

      // Watchdog on a head PE that never acks
      randomize_data();
      arm();
      ack_mode = 1;
      pulse_start();
      wait_stb("to_offer_reached");
      for (int i = 1; i < TO; i++) begin
         @(negedge clk);
         chk("to_stb_hold", pe_stb, 1);
         chk("to_err_hold", error, 0);
      end
      @(negedge clk);
      chk("to_stb_drop", pe_stb, 0);
      chk("to_error", error, 1);
      chk("to_busy", busy, 0);
      d0 = dones;
      repeat (10) @(negedge clk);
      chk("to_no_done", dones - d0, 0);
      chk("to_error_sticky", error, 1);
      ack_mode = 0;
      run_job("after_timeout");

      // Backpressure on the second result word
      randomize_data();
      cons_mode = 2;
      run_job("stall");
      chk("stall_cycles", stall, 7);
      cons_mode = 0;

      // start pulses during OFFER and OUT are ignored
      randomize_data();
      arm();
      ack_dly = 4; cons_mode = 3;
      d0 = dones;
      pulse_start();
      wait_stb("ign_offer_reached");
      pulse_start();
      k = 0;
      while (!res_valid && k < 500) begin @(negedge clk); k++; end
      chk("ign_out_reached", res_valid, 1);
      pulse_start();
      cons_mode = 0;
      k = 0;
      while (dones == d0 && k < 500) begin @(negedge clk); k++; end
      repeat (15) @(negedge clk);
      chk("ign_done_count", dones - d0, 1);
      chk("ign_beats", beats, NB);
      chk("ign_results", xfers, NN);
      chk("ign_busy_idle", busy, 0);
      ack_dly = 2;

      // Asynchronous reset in the middle of OFFER
      randomize_data();
      arm();
      ack_dly = 4;
      pulse_start();
      wait_stb("rst_offer_reached");
      #2 rst = 1'b0;
      #1;
      chk("amid_stb", pe_stb, 0);
      chk("amid_busy", busy, 0);
      chk("amid_rvalid", res_valid, 0);
      chk("amid_pe_a", pe_a, 0);
      @(posedge clk); #2 rst = 1'b1;
      ack_dly = 2;
      run_job("after_reset");

      // Ack held high into the next OFFER
      randomize_data();
      ack_mode = 2;
      run_job("stuck_ack");
      ack_mode = 0;

      // Randomized jobs
      for (int r = 0; r < 8; r++) begin
         randomize_data();
         ack_dly   = $urandom_range(1, 4);
         out_dly   = $urandom_range(1, 8);
         cons_mode = $urandom_range(0, 1);
         run_job("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
